mwpram_wsched: RTL and testbench

Write-port scheduler and initialiser placed in front of an mwpram instance. It shares the RAM's wports write ports among nreq requesters using valid/ready handshakes and round-robin priority, and it blocks same-address collisions within a cycle. Because the RAM has no reset, the block also sweeps every entry to a known value after reset and on command. Typical uses are register-file or rename-table write arbitration.

---
 rtl/mwpram_pkg.sv | 14 +
 rtl/mwpram_rr_pick.sv | 53 +++++
 rtl/mwpram_wsched.sv | 179 +++++++++++++++++
 tb/tb_mwpram_wsched.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mwpram_pkg.sv
// Shared types and helpers for the mwpram write scheduler.
package mwpram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } sched_state_e;

  // Index/address width for n items; never below one bit so ports stay legal.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mwpram_rr_pick.sv
// Round-robin picker: scans requesters from i_ptr and grants up to wports of
// them with pairwise-distinct addresses; reports each grant's write-port slot.
module mwpram_rr_pick
  import mwpram_pkg::*;
#(
  parameter int nreq   = 4,
  parameter int wports = 2,
  parameter int aw     = 6,
  parameter int pw     = addr_w(nreq),
  parameter int qw     = addr_w(wports)
) (
  input  logic [nreq-1:0]    i_valid,
  input  logic [nreq*aw-1:0] i_addr,
  input  logic [pw-1:0]      i_ptr,
  output logic [nreq-1:0]    o_grant,
  output logic [nreq*qw-1:0] o_port_idx,
  output logic [pw-1:0]      o_ptr_next,
  output logic               o_conflict
);

  always_comb begin
    logic [pw-1:0] k;
    logic [pw-1:0] k_inc;
    logic [qw:0]   n;
    logic          hit;
    o_grant    = '0;
    o_port_idx = '0;
    o_ptr_next = i_ptr;
    o_conflict = 1'b0;
    k          = i_ptr;
    n          = '0;
    for (int s = 0; s < nreq; s++) begin
      hit = 1'b0;
      for (int j = 0; j < nreq; j++) begin
        if (o_grant[j] && (i_addr[j*aw +: aw] == i_addr[k*aw +: aw])) hit = 1'b1;
      end
      k_inc = (k == pw'(nreq - 1)) ? '0 : k + 1'b1;
      // A same-address refusal counts as a conflict even once ports are full.
      if (i_valid[k]) begin
        if (hit) begin
          o_conflict = 1'b1;
        end else if (n < (qw+1)'(wports)) begin
          o_grant[k]                = 1'b1;
          o_port_idx[k*qw +: qw]    = n[qw-1:0];
          n                         = n + 1'b1;
          o_ptr_next                = k_inc;
        end
      end
      k = k_inc;
    end
  end

endmodule

// File: rtl/mwpram_wsched.sv
// Write-port scheduler and initialiser in front of an mwpram instance.
// Define MWPSCHED_STATS_EN to add the stat_conflict/stat_stall counters.
module mwpram_wsched
  import mwpram_pkg::*;
#(
  parameter int               width      = 64,
  parameter int               depth      = 64,
  parameter int               wports     = 2,
  parameter int               nreq       = 4,
  parameter logic [width-1:0] init_value = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr,
  input  logic [nreq-1:0]                 req_valid,
  output logic [nreq-1:0]                 req_ready,
  input  logic [nreq*addr_w(depth)-1:0]   req_addr,
  input  logic [nreq*width-1:0]           req_data,
  output logic [wports*addr_w(depth)-1:0] waddr,
  output logic [wports*width-1:0]         wvalue,
  output logic [wports-1:0]               wena,
  output logic                            busy
`ifdef MWPSCHED_STATS_EN
  ,
  output logic [31:0]                     stat_conflict,
  output logic [31:0]                     stat_stall
`endif
);

  localparam int aw = addr_w(depth);
  localparam int pw = addr_w(nreq);
  localparam int qw = addr_w(wports);
  localparam int cw = addr_w(depth + wports) + 1;

  typedef struct packed {
    logic [aw-1:0]    addr;
    logic [width-1:0] data;
  } wr_req_t;

  sched_state_e       r_state, w_state_next;
  logic [cw-1:0]      r_cnt, w_cnt_next;
  logic [pw-1:0]      r_ptr, w_ptr_next, w_pick_ptr;
  logic [wports-1:0]  r_wena, w_wena_next;
  logic [aw-1:0]      r_waddr  [wports];
  logic [aw-1:0]      w_waddr_next [wports];
  logic [width-1:0]   r_wvalue [wports];
  logic [width-1:0]   w_wvalue_next [wports];
  logic [nreq-1:0]    w_grant;
  logic [nreq*qw-1:0] w_port_idx;
  logic               w_conflict;
  wr_req_t            w_req [nreq];

  genvar gi;
  generate
    for (gi = 0; gi < nreq; gi++) begin : g_req
      assign w_req[gi] = {req_addr[gi*aw +: aw], req_data[gi*width +: width]};
    end
    for (gi = 0; gi < wports; gi++) begin : g_port
      assign waddr[gi*aw +: aw]          = r_waddr[gi];
      assign wvalue[gi*width +: width]   = r_wvalue[gi];
    end
  endgenerate

  mwpram_rr_pick #(
    .nreq   (nreq),
    .wports (wports),
    .aw     (aw),
    .pw     (pw),
    .qw     (qw)
  ) u_pick (
    .i_valid    (req_valid),
    .i_addr     (req_addr),
    .i_ptr      (r_ptr),
    .o_grant    (w_grant),
    .o_port_idx (w_port_idx),
    .o_ptr_next (w_pick_ptr),
    .o_conflict (w_conflict)
  );

  assign wena      = r_wena;
  assign busy      = (r_state == INIT);
  assign req_ready = ((r_state == RUN) && !clr) ? w_grant : '0;

  always_comb begin
    logic [cw-1:0] sum;
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_ptr_next   = r_ptr;
    w_wena_next  = '0;
    sum          = '0;
    for (int p = 0; p < wports; p++) begin
      w_waddr_next[p]  = '0;
      w_wvalue_next[p] = '0;
    end
    case (r_state)
      INIT: begin
        if (clr) begin
          w_cnt_next = '0;
        end else begin
          for (int p = 0; p < wports; p++) begin
            sum = r_cnt + cw'(p);
            if (sum < cw'(depth)) begin
              w_wena_next[p]   = 1'b1;
              w_waddr_next[p]  = sum[aw-1:0];
              w_wvalue_next[p] = init_value;
            end
          end
          w_cnt_next = r_cnt + cw'(wports);
          if (r_cnt + cw'(wports) >= cw'(depth)) begin
            w_state_next = RUN;
            w_cnt_next   = '0;
            w_ptr_next   = '0;
          end
        end
      end
      default: begin
        if (clr) begin
          w_state_next = INIT;
          w_cnt_next   = '0;
          w_ptr_next   = '0;
        end else begin
          // n-th grant in scan order lands on write port n.
          for (int p = 0; p < wports; p++) begin
            for (int k = 0; k < nreq; k++) begin
              if (w_grant[k] && (w_port_idx[k*qw +: qw] == qw'(p))) begin
                w_wena_next[p]   = 1'b1;
                w_waddr_next[p]  = w_req[k].addr;
                w_wvalue_next[p] = w_req[k].data;
              end
            end
          end
          w_ptr_next = w_pick_ptr;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= INIT;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_wena  <= '0;
      for (int p = 0; p < wports; p++) begin
        r_waddr[p]  <= '0;
        r_wvalue[p] <= '0;
      end
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_ptr   <= w_ptr_next;
      r_wena  <= w_wena_next;
      for (int p = 0; p < wports; p++) begin
        r_waddr[p]  <= w_waddr_next[p];
        r_wvalue[p] <= w_wvalue_next[p];
      end
    end
  end

`ifdef MWPSCHED_STATS_EN
  logic [31:0] r_stat_conflict, r_stat_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_conflict <= '0;
      r_stat_stall    <= '0;
    end else if (r_state == RUN) begin
      if (!clr && w_conflict && (r_stat_conflict != '1))
        r_stat_conflict <= r_stat_conflict + 1'b1;
      if ((|(req_valid & ~req_ready)) && (r_stat_stall != '1))
        r_stat_stall <= r_stat_stall + 1'b1;
    end
  end

  assign stat_conflict = r_stat_conflict;
  assign stat_stall    = r_stat_stall;
`endif

endmodule

// File: tb/tb_mwpram_wsched.sv
// Randomised self-checking bench for mwpram_wsched against a cycle-level
// behavioural model of the sweep, round-robin grants and write-port outputs.
module tb_mwpram_wsched;

  localparam int W  = 64;
  localparam int D  = 64;
  localparam int WP = 2;
  localparam int NR = 4;
  localparam int AW = 6;
  localparam logic [W-1:0] IV = 64'hC0DE_5A5A_0F0F_1234;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clr = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_ready;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*W-1:0]  req_data = '0;
  logic [WP*AW-1:0] waddr;
  logic [WP*W-1:0]  wvalue;
  logic [WP-1:0]    wena;
  logic             busy;
`ifdef MWPSCHED_STATS_EN
  logic [31:0] stat_conflict, stat_stall, s_stat_conflict, s_stat_stall;
`endif

  // Small instance: depth 5, two ports, three-cycle sweep.
  logic       s_rst = 1'b1;
  logic       s_clr = 1'b0;
  logic [1:0] s_req_valid = '0;
  logic [1:0] s_req_ready;
  logic [5:0] s_req_addr = '0;
  logic [15:0] s_req_data = '0;
  logic [5:0] s_waddr;
  logic [15:0] s_wvalue;
  logic [1:0] s_wena;
  logic       s_busy;

  always #5 clk = ~clk;

  mwpram_wsched #(.width(W), .depth(D), .wports(WP), .nreq(NR), .init_value(IV)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_data(req_data),
    .waddr(waddr), .wvalue(wvalue), .wena(wena), .busy(busy)
`ifdef MWPSCHED_STATS_EN
    , .stat_conflict(stat_conflict), .stat_stall(stat_stall)
`endif
  );

  mwpram_wsched #(.width(8), .depth(5), .wports(2), .nreq(2), .init_value(8'h3C)) dut_s (
    .clk(clk), .rst(s_rst), .clr(s_clr),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_addr(s_req_addr), .req_data(s_req_data),
    .waddr(s_waddr), .wvalue(s_wvalue), .wena(s_wena), .busy(s_busy)
`ifdef MWPSCHED_STATS_EN
    , .stat_conflict(s_stat_conflict), .stat_stall(s_stat_stall)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  bit          m_init;
  int          m_sweep;
  int          m_ptr;
  int          m_conf;
  int          m_stall;
  bit [WP-1:0] exp_wena;
  logic [AW-1:0] exp_waddr [WP];
  logic [W-1:0]  exp_wvalue[WP];
  bit            pend_valid[NR];
  logic [AW-1:0] pend_addr [NR];
  logic [W-1:0]  pend_data [NR];
  bit            auto_gen;
  bit            tally_on;
  int            tally[D];
  int            tally_badval;
  logic [NR-1:0] obs_ready;
  bit            obs_busy;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < NR; k++) begin
      req_valid[k]           = pend_valid[k];
      req_addr[k*AW +: AW]   = pend_addr[k];
      req_data[k*W +: W]     = pend_data[k];
    end
  endtask

  task automatic new_req(input int k);
    pend_valid[k] = 1'b1;
    pend_addr[k]  = AW'($urandom_range(0, 7));
    pend_data[k]  = {$urandom(), $urandom()};
  endtask

  // One clock: check outputs at negedge against the model, then advance it.
  task automatic step();
    int            gk[$];
    int            ga[$];
    bit [NR-1:0]   mr;
    bit            conf;
    bit            stall;
    bit            seen;
    int            a;
    bit [WP-1:0]   nx_wena;
    logic [AW-1:0] nx_addr[WP];
    logic [W-1:0]  nx_val [WP];
    @(negedge clk);
    obs_busy = busy;
    chk("busy", 64'(busy), 64'(m_init));
    chk("wena", 64'(wena), 64'(exp_wena));
    for (int p = 0; p < WP; p++) begin
      if (exp_wena[p]) begin
        chk("waddr", 64'(waddr[p*AW +: AW]), 64'(exp_waddr[p]));
        chk("wvalue", wvalue[p*W +: W], exp_wvalue[p]);
      end
      if (tally_on && wena[p]) begin
        a = int'(waddr[p*AW +: AW]);
        tally[a]++;
        if (wvalue[p*W +: W] !== IV) tally_badval++;
      end
    end
    mr = '0; nx_wena = '0; conf = 1'b0; stall = 1'b0;
    for (int p = 0; p < WP; p++) begin
      nx_addr[p] = '0;
      nx_val[p]  = '0;
    end
    if (m_init) begin
      if (!clr) begin
        for (int p = 0; p < WP; p++) begin
          a = m_sweep * WP + p;
          if (a < D) begin
            nx_wena[p] = 1'b1;
            nx_addr[p] = AW'(a);
            nx_val[p]  = IV;
          end
        end
      end
    end else if (!clr) begin
      for (int s = 0; s < NR; s++) begin
        int k;
        k = (m_ptr + s) % NR;
        if (pend_valid[k]) begin
          seen = 1'b0;
          foreach (ga[i]) if (ga[i] == int'(pend_addr[k])) seen = 1'b1;
          if (seen) conf = 1'b1;
          else if (ga.size() < WP) begin
            nx_wena[ga.size()] = 1'b1;
            nx_addr[ga.size()] = pend_addr[k];
            nx_val[ga.size()]  = pend_data[k];
            ga.push_back(int'(pend_addr[k]));
            gk.push_back(k);
            mr[k] = 1'b1;
          end
        end
      end
    end
    if (!m_init)
      for (int k = 0; k < NR; k++) if (pend_valid[k] && !mr[k]) stall = 1'b1;
    obs_ready = req_ready;
    chk("ready", 64'(req_ready), 64'(mr));
    @(posedge clk);
    exp_wena = nx_wena;
    for (int p = 0; p < WP; p++) begin
      exp_waddr[p]  = nx_addr[p];
      exp_wvalue[p] = nx_val[p];
    end
    if (!m_init) begin
      if (conf) m_conf++;
      if (stall) m_stall++;
    end
    if (m_init) begin
      if (clr) m_sweep = 0;
      else begin
        m_sweep++;
        if (m_sweep * WP >= D) begin
          m_init = 1'b0;
          m_ptr  = 0;
        end
      end
    end else if (clr) begin
      m_init = 1'b1; m_sweep = 0; m_ptr = 0;
    end else if (gk.size() > 0) begin
      m_ptr = (gk[gk.size()-1] + 1) % NR;
    end
    foreach (gk[i]) pend_valid[gk[i]] = 1'b0;
    if (auto_gen)
      for (int k = 0; k < NR; k++)
        if (!pend_valid[k] && ($urandom_range(0, 3) != 0)) new_req(k);
    #1;
    drive_inputs();
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    chk({tag, "_wena"}, 64'(wena), 64'd0);
    chk({tag, "_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_waddr"}, 64'(waddr), 64'd0);
    chk({tag, "_wvalue"}, 64'(wvalue[W-1:0]), 64'd0);
    m_init = 1'b1; m_sweep = 0; m_ptr = 0; exp_wena = '0;
    m_conf = 0; m_stall = 0;
    for (int k = 0; k < NR; k++) begin
      pend_valid[k] = 1'b0; pend_addr[k] = '0; pend_data[k] = '0;
    end
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Steps through a sweep, tallying writes; ends on the first non-busy cycle.
  task automatic run_sweep(input string tag);
    int n;
    int wrong;
    n = 0; wrong = 0; tally_badval = 0;
    for (int i = 0; i < D; i++) tally[i] = 0;
    tally_on = 1'b1;
    for (int c = 0; c < 100; c++) begin
      step();
      if (obs_busy) n++;
      else break;
    end
    tally_on = 1'b0;
    for (int i = 0; i < D; i++) if (tally[i] != 1) wrong++;
    chk({tag, "_busy_cycles"}, 64'(n), 64'd32);
    chk({tag, "_addr_once"}, 64'(wrong), 64'd0);
    chk({tag, "_init_value"}, 64'(tally_badval), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, nw;
    logic [1:0] lw;
    logic [2:0] la;
    auto_gen = 1'b0;
    tally_on = 1'b0;
    #2;
    do_reset("rst0");
    run_sweep("sweep0");

    // All four valid with distinct addresses from ptr 0.
    for (int k = 0; k < NR; k++) begin
      pend_valid[k] = 1'b1; pend_addr[k] = AW'(10 + k); pend_data[k] = 64'h1000 + 64'(k);
    end
    drive_inputs();
    step(); chk("t2_ready_a", 64'(obs_ready), 64'b0011);
    step(); chk("t2_ready_b", 64'(obs_ready), 64'b1100);
    step();

    // Requesters 0 and 1 collide on address 5.
    pend_valid[0] = 1'b1; pend_addr[0] = 6'd5; pend_data[0] = 64'hAAAA;
    pend_valid[1] = 1'b1; pend_addr[1] = 6'd5; pend_data[1] = 64'hBBBB;
    pend_valid[2] = 1'b1; pend_addr[2] = 6'd9; pend_data[2] = 64'hCCCC;
    pend_valid[3] = 1'b0;
    drive_inputs();
    step(); chk("t3_ready_a", 64'(obs_ready), 64'b0101);
    step(); chk("t3_ready_b", 64'(obs_ready), 64'b0010);
    step();

    // clr in RUN with requests pending.
    for (int k = 0; k < NR; k++) begin
      pend_valid[k] = 1'b1; pend_addr[k] = AW'(20 + k); pend_data[k] = 64'h2000 + 64'(k);
    end
    drive_inputs();
    clr = 1'b1;
    step(); chk("t4_clr_ready", 64'(obs_ready), 64'd0);
    clr = 1'b0;
    run_sweep("sweep_clr");
    chk("t4_ready_after", 64'(obs_ready), 64'b0011);

    // Randomised traffic with occasional clr.
    auto_gen = 1'b1;
    for (int c = 0; c < 400; c++) begin
      clr = ($urandom_range(0, 59) == 0);
      step();
    end
    clr = 1'b0;
    auto_gen = 1'b0;
    for (int c = 0; c < 40; c++) step();

`ifdef MWPSCHED_STATS_EN
    chk("stat_conflict", 64'(stat_conflict), 64'(m_conf));
    chk("stat_stall", 64'(stat_stall), 64'(m_stall));
`endif

    // Reset asserted mid-sweep at cnt=20.
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int c = 0; c < 10; c++) step();
    chk("t5_pre_wena", 64'(wena), 64'b11);
    do_reset("t5");
    run_sweep("sweep_rst");

    // Small instance: depth 5, three sweep cycles, last one on port 0 only.
    s_rst = 1'b0;
    #1;
    chk("t6_rst_busy", 64'(s_busy), 64'd1);
    chk("t6_rst_wena", 64'(s_wena), 64'd0);
    @(posedge clk);
    #1;
    s_rst = 1'b1;
    nb = 0; nw = 0; lw = '0; la = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (s_busy) nb++;
      for (int p = 0; p < 2; p++) if (s_wena[p]) nw++;
      if (s_wena != 2'b00) begin
        lw = s_wena;
        la = s_waddr[2:0];
      end
    end
    chk("t6_busy_cycles", 64'(nb), 64'd3);
    chk("t6_writes", 64'(nw), 64'd5);
    chk("t6_last_wena", 64'(lw), 64'b01);
    chk("t6_last_waddr", 64'(la), 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
